// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, NOP register index and the MEM/WB control bundle
// used by the id_ex, ex_mem and mem_wb pipeline registers.
package cpu_pkg;
    localparam int DATA_W = 16;
    localparam int REG_W  = 4;
    localparam logic [REG_W-1:0] NOP_REG = 4'b0000;

    typedef struct packed {
        logic regwrite;
        logic memtoreg;
        logic memread;
        logic memwrite;
    } mem_wb_ctrl_t;
endpackage

// File: rtl/pipe_field.sv
// pipe_field: W-bit pipeline flop with async active-high reset,
// synchronous clear (flush) and a hold enable.
module pipe_field #(
    parameter int W = 1
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    // Clear beats hold so a flushed slot never keeps a squashed instruction.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            q <= '0;
        else if (clr)
            q <= '0;
        else if (en)
            q <= d;
    end
endmodule

// File: rtl/ex_mem_reg.sv
// ex_mem_reg: EX/MEM pipeline register; flush inserts an all-zero bubble.
// Define EXMEM_STALL_EN to add the stall_i hold input.
module ex_mem_reg #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int REG_W  = cpu_pkg::REG_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              flush_ex_i,
`ifdef EXMEM_STALL_EN
    input  logic              stall_i,
`endif
    input  logic              regwrite_i,
    input  logic              memtoreg_i,
    input  logic              memread_i,
    input  logic              memwrite_i,
    input  logic [DATA_W-1:0] memdata_i,
    input  logic [REG_W-1:0]  regdst_i,
    input  logic [DATA_W-1:0] alures_i,
    output logic              regwrite_o,
    output logic              memtoreg_o,
    output logic              memread_o,
    output logic              memwrite_o,
    output logic [DATA_W-1:0] memdata_o,
    output logic [REG_W-1:0]  regdst_o,
    output logic [DATA_W-1:0] alures_o
);
    import cpu_pkg::*;

    mem_wb_ctrl_t ctrl_d, ctrl_q;
    logic en;

`ifdef EXMEM_STALL_EN
    assign en = ~stall_i;
`else
    assign en = 1'b1;
`endif

    assign ctrl_d = '{regwrite: regwrite_i, memtoreg: memtoreg_i,
                      memread: memread_i, memwrite: memwrite_i};

    pipe_field #(.W($bits(mem_wb_ctrl_t))) u_ctrl (
        .CLK(CLK), .RST(RST), .clr(flush_ex_i), .en(en), .d(ctrl_d), .q(ctrl_q)
    );
    pipe_field #(.W(REG_W)) u_regdst (
        .CLK(CLK), .RST(RST), .clr(flush_ex_i), .en(en), .d(regdst_i), .q(regdst_o)
    );
    pipe_field #(.W(DATA_W)) u_memdata (
        .CLK(CLK), .RST(RST), .clr(flush_ex_i), .en(en), .d(memdata_i), .q(memdata_o)
    );
    pipe_field #(.W(DATA_W)) u_alures (
        .CLK(CLK), .RST(RST), .clr(flush_ex_i), .en(en), .d(alures_i), .q(alures_o)
    );

    assign regwrite_o = ctrl_q.regwrite;
    assign memtoreg_o = ctrl_q.memtoreg;
    assign memread_o  = ctrl_q.memread;
    assign memwrite_o = ctrl_q.memwrite;
endmodule

// File: tb/tb_ex_mem_reg.sv
// tb_ex_mem_reg: scoreboard bench for ex_mem_reg; expected outputs are queued
// per clock edge and checked by an independent monitor.
module tb_ex_mem_reg;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        flush_ex_i = 1'b0;
    logic        stall = 1'b0;
    logic        regwrite_i = 1'b1, memtoreg_i = 1'b1, memread_i = 1'b1, memwrite_i = 1'b1;
    logic [15:0] memdata_i = '1;
    logic [3:0]  regdst_i = '1;
    logic [15:0] alures_i = '1;
    logic        regwrite_o, memtoreg_o, memread_o, memwrite_o;
    logic [15:0] memdata_o;
    logic [3:0]  regdst_o;
    logic [15:0] alures_o;

    int checks = 0;
    int failures = 0;
    logic [39:0] exp_q[$];
    logic [39:0] cur = '0;

    ex_mem_reg dut (
        .CLK(CLK), .RST(RST), .flush_ex_i(flush_ex_i),
`ifdef EXMEM_STALL_EN
        .stall_i(stall),
`endif
        .regwrite_i(regwrite_i), .memtoreg_i(memtoreg_i), .memread_i(memread_i),
        .memwrite_i(memwrite_i), .memdata_i(memdata_i), .regdst_i(regdst_i),
        .alures_i(alures_i), .regwrite_o(regwrite_o), .memtoreg_o(memtoreg_o),
        .memread_o(memread_o), .memwrite_o(memwrite_o), .memdata_o(memdata_o),
        .regdst_o(regdst_o), .alures_o(alures_o)
    );

    always #5 CLK = ~CLK;

    function automatic logic [39:0] outs();
        return {regwrite_o, memtoreg_o, memread_o, memwrite_o, regdst_o, memdata_o, alures_o};
    endfunction

    function automatic logic [39:0] ins();
        return {regwrite_i, memtoreg_i, memread_i, memwrite_i, regdst_i, memdata_i, alures_i};
    endfunction

    task automatic chk(input string name, input logic [39:0] got, input logic [39:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic set_ins(input logic [39:0] v);
        {regwrite_i, memtoreg_i, memread_i, memwrite_i, regdst_i, memdata_i, alures_i} = v;
    endtask

    // Drive one cycle's inputs at the falling edge and queue what the next
    // rising edge must produce: reset and flush give zero, stall keeps, else capture.
    task automatic drive(input logic r, input logic f, input logic s, input logic [39:0] v);
        @(negedge CLK);
        RST = r;
        flush_ex_i = f;
        stall = s;
        set_ins(v);
`ifdef EXMEM_STALL_EN
        cur = r ? 40'd0 : f ? 40'd0 : s ? cur : v;
`else
        cur = r ? 40'd0 : f ? 40'd0 : v;
`endif
        exp_q.push_back(cur);
    endtask

    initial begin : monitor
        forever begin
            @(posedge CLK);
            #1;
            if (exp_q.size() > 0) chk("edge", outs(), exp_q.pop_front());
        end
    end

    initial begin : stim
        logic [39:0] cap, a, b;
        logic use_stall;
        cap = {4'b1110, 4'b0011, 16'hABCD, 16'h5CBA};
`ifdef EXMEM_STALL_EN
        use_stall = 1'b1;
`else
        use_stall = 1'b0;
`endif
        #1;
        chk("reset_before_edge", outs(), 40'd0);
        drive(1'b1, 1'b0, 1'b0, '1);
        drive(1'b1, 1'b0, 1'b0, '1);

        drive(1'b0, 1'b0, 1'b0, cap);
        #1;
        chk("unchanged_before_edge", outs(), 40'd0);
        drive(1'b0, 1'b1, 1'b0, cap);
        drive(1'b0, 1'b0, 1'b0, cap);

        // Mid-cycle input changes must not reach the outputs.
        a = {$urandom, $urandom};
        drive(1'b0, 1'b0, 1'b0, a);
        @(posedge CLK);
        #2;
        set_ins(~a);
        flush_ex_i = 1'b1;
        #1;
        flush_ex_i = 1'b0;
        chk("hold_between_edges", outs(), a);

        // Asynchronous reset between edges.
        RST = 1'b1;
        #1;
        chk("async_reset", outs(), 40'd0);
        cur = '0;
        b = {$urandom, $urandom};
        drive(1'b0, 1'b0, 1'b0, b);

`ifdef EXMEM_STALL_EN
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b1, {$urandom, $urandom});
        drive(1'b0, 1'b1, 1'b1, {$urandom, $urandom});
`endif

        for (int i = 0; i < 300; i++)
            drive(($urandom_range(0, 31) == 0), ($urandom_range(0, 7) == 0),
                  use_stall & ($urandom_range(0, 3) == 0), {$urandom, $urandom});
        drive(1'b0, 1'b0, 1'b0, cap);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge CLK);
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL drain: %0d expected edges never checked", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ex_mem_reg.md
Name: ex_mem_reg

Overview:
- EX/MEM pipeline register of the 16-bit five-stage CPU.
- Captures the ALU result, store data, destination register and MEM/WB control bits from the execute stage on each rising clock edge.
- Presents the captured values to the memory stage for one cycle.
- A flush input replaces the captured instruction with a bubble (NOP), so a squashed instruction cannot write memory or the register file.

Parameters:
- DATA_W, 16, width of ALU result and store data.
- REG_W, 4, width of destination-register index.

Ports:
- CLK  input  1  system clock, rising-edge active.
- RST  input  1  asynchronous, active-high reset.
- flush_ex_i  input  1  squash the incoming EX instruction (insert bubble).
- regwrite_i  input  1  WB: write register file.
- memtoreg_i  input  1  WB: select memory data for write-back.
- memread_i  input  1  MEM: data-memory read.
- memwrite_i  input  1  MEM: data-memory write.
- memdata_i  input  DATA_W  store data (rt value).
- regdst_i  input  REG_W  destination register index.
- alures_i  input  DATA_W  ALU result / memory address.
- regwrite_o, memtoreg_o, memread_o, memwrite_o  output  1 each  registered control.
- memdata_o  output  DATA_W  registered store data.
- regdst_o  output  REG_W  registered destination.
- alures_o  output  DATA_W  registered ALU result.

Behaviour:
- One clock; reset is asynchronous and active-high (ports CLK, RST).
- RST=1 forces all outputs to 0 immediately, independent of CLK, and holds them at 0 while asserted.
- Release of RST takes effect on the next rising edge.
- All outputs are driven directly from flops; no combinational path from input to output.
- Latency is exactly 1 cycle.
- Rising edge, RST=0, flush_ex_i=0: every output takes the value of its corresponding input.
- Rising edge, RST=0, flush_ex_i=1: all outputs load 0 (control, regdst, memdata, alures), regardless of the other inputs. Register index 0 plus regwrite=0 is the canonical NOP.
- Flush is sampled only at the rising edge. A flush pulse that does not span an edge has no effect.
- Outputs between edges hold their last value; input glitches between edges are ignored.
- Width rule: inputs are captured bit-for-bit; no sign or zero extension inside the block.
- Priority: RST > flush_ex_i > (optional stall) > normal capture.

Optional Feature:
- Macro EXMEM_STALL_EN.
- When defined: adds input port stall_i (1 bit, placed after flush_ex_i).
  - Rising edge with stall_i=1 and flush_ex_i=0: all outputs hold their current values.
  - flush_ex_i=1 still clears, even if stall_i=1.
- When not defined: no stall_i port; the register captures or flushes every edge.

Decomposition:
- Shared package cpu_pkg holds:
  - DATA_W=16 and REG_W=4 constants.
  - A NOP_REG constant (4'b0000).
  - A typedef for the 4-bit MEM/WB control bundle {regwrite, memtoreg, memread, memwrite}, shared with id_ex and mem_wb.
- One natural sub-module: pipe_field, a width-parameterised flop with async active-high reset, synchronous clear (flush) and optional hold enable. It is instantiated once per field (control bundle, regdst, memdata, alures).

Test Plan:
- Reset: RST=1 with inputs at all-ones → all outputs 0 immediately, before any clock edge. They stay 0 through 2 edges while RST=1.
- Capture: RST=0, flush=0, regwrite=1, memtoreg=1, memread=1, memwrite=0, memdata=16'hABCD, regdst=4'b0011, alures=16'h5CBA, then one edge → outputs equal those values. They are unchanged before the edge.
- Flush: same inputs with flush_ex_i=1 at the edge → all outputs 0. The next edge with flush=0 captures the inputs again.
- Between edges: change all inputs mid-cycle → outputs unchanged until the next rising edge.
- Async reset mid-operation: after a capture, assert RST between edges → outputs 0 at once. Deassert, then one edge with flush=0 → outputs reload from inputs.
- (EXMEM_STALL_EN) Stall then flush:
  - stall_i=1 with new inputs → outputs hold previous values for 3 edges.
  - stall_i=1 with flush_ex_i=1 → outputs 0.
